// File: rtl/mem_write_master_pkg.sv
// Shared AXI encodings and FSM state type for the WR_BUF drain master.
package mem_write_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_write_master.sv
// AXI4 write master draining WR_BUF into DRAM as INCR bursts, one burst outstanding.
// Pulses done after the final B response; wr_error records any non-OKAY BRESP.
module mem_write_master
  import mem_write_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN      = 16,
  parameter int TX_SIZE_WIDTH  = 20
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [TX_SIZE_WIDTH-1:0]    num_beats,
  output logic                        busy,
  output logic                        done,
  output logic                        wr_error,
  input  logic                        WR_BUF_EMPTY,
  input  logic [AXI_DATA_WIDTH-1:0]   WR_BUF_DATA,
  output logic                        WR_BUF_POP,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [7:0]                  M_AWLEN,
  output logic [2:0]                  M_AWSIZE,
  output logic [1:0]                  M_AWBURST,
  output logic                        M_AWVALID,
  input  logic                        M_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                        M_WLAST,
  output logic                        M_WVALID,
  input  logic                        M_WREADY,
  input  logic [1:0]                  M_BRESP,
  input  logic                        M_BVALID,
  output logic                        M_BREADY
);

  localparam int BYTES      = AXI_DATA_WIDTH / 8;
  localparam int BEAT_W     = $clog2(BURST_LEN + 1);
  localparam int ADDR_SHIFT = $clog2(BYTES);
  localparam logic [2:0] AW_SIZE = 3'(ADDR_SHIFT);

  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [TX_SIZE_WIDTH-1:0]  remaining_q;
  logic [BEAT_W-1:0]         burst_beats_q;
  logic [BEAT_W-1:0]         beat_cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      wr_error_q;

  logic [BEAT_W-1:0]         burst_now;
  logic                      w_hs;

  function automatic logic [BEAT_W-1:0] burst_size(input logic [TX_SIZE_WIDTH-1:0] rem);
    if (rem >= TX_SIZE_WIDTH'(BURST_LEN))
      return BEAT_W'(BURST_LEN);
    return BEAT_W'(rem);
  endfunction

  // remaining_q is frozen while in AW, so AWLEN stays stable until AWREADY.
  assign burst_now  = burst_size(remaining_q);

  assign M_AWADDR   = addr_q;
  assign M_AWLEN    = 8'(burst_now - BEAT_W'(1));
  assign M_AWSIZE   = AW_SIZE;
  assign M_AWBURST  = AXI_BURST_INCR;
  assign M_AWVALID  = (state_q == ST_AW);

  assign M_WVALID   = (state_q == ST_W) && !WR_BUF_EMPTY;
  assign M_WDATA    = WR_BUF_DATA;
  assign M_WSTRB    = '1;
  assign M_WLAST    = M_WVALID && (beat_cnt_q == burst_beats_q - BEAT_W'(1));
  assign w_hs       = M_WVALID && M_WREADY;
  assign WR_BUF_POP = w_hs;

  assign M_BREADY   = (state_q == ST_B);

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_error   = wr_error_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            wr_error_q  <= 1'b0;
            addr_q      <= base_addr;
            remaining_q <= num_beats;
            if (num_beats == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_AW;
            end
          end
        end
        ST_AW: begin
          beat_cnt_q <= '0;
          if (M_AWREADY) begin
            burst_beats_q <= burst_now;
            addr_q        <= addr_q + (AXI_ADDR_WIDTH'(burst_now) << ADDR_SHIFT);
            remaining_q   <= remaining_q - TX_SIZE_WIDTH'(burst_now);
            state_q       <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (M_WLAST)
              state_q <= ST_B;
          end
        end
        ST_B: begin
          if (M_BVALID) begin
            if (M_BRESP != AXI_RESP_OKAY)
              wr_error_q <= 1'b1;
            if (remaining_q == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_AW;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_master.sv
// Directed bench for mem_write_master: model WR_BUF and AXI slave, check bursts, stalls, errors, reset.
module tb_mem_write_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [19:0] num_beats = '0;
  logic        busy, done, wr_error;
  logic        WR_BUF_EMPTY;
  logic [63:0] WR_BUF_DATA;
  logic        WR_BUF_POP;
  logic [31:0] M_AWADDR;
  logic [7:0]  M_AWLEN;
  logic [2:0]  M_AWSIZE;
  logic [1:0]  M_AWBURST;
  logic        M_AWVALID;
  logic        M_AWREADY = 1'b0;
  logic [63:0] M_WDATA;
  logic [7:0]  M_WSTRB;
  logic        M_WLAST, M_WVALID;
  logic        M_WREADY = 1'b0;
  logic [1:0]  M_BRESP = 2'b00;
  logic        M_BVALID = 1'b0;
  logic        M_BREADY;

  always #5 ACLK = ~ACLK;

  mem_write_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .wr_error(wr_error),
    .WR_BUF_EMPTY(WR_BUF_EMPTY), .WR_BUF_DATA(WR_BUF_DATA), .WR_BUF_POP(WR_BUF_POP),
    .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
  );

  int checks = 0;
  int errors = 0;

  // WR_BUF model: word i of the stream is word(i); buf_limit is how many have been pushed.
  int rd_ptr = 0;
  int buf_limit = 0;
  function automatic logic [63:0] word(input int i);
    return {32'hC0DE_0000 + 32'(i), ~32'(i)};
  endfunction
  assign WR_BUF_EMPTY = (rd_ptr >= buf_limit);
  assign WR_BUF_DATA  = word(rd_ptr);
  always @(posedge ACLK) if (WR_BUF_POP) rd_ptr <= rd_ptr + 1;

  // Slave handshake monitor, sampled mid-cycle.
  int aw_total = 0, w_total = 0, wlast_total = 0, b_total = 0, pop_total = 0;
  int data_err = 0, wlast_bad = 0, stable_viol = 0, pop_empty = 0, awvalid_cycles = 0;
  int beat_in = 0;
  logic [31:0] aw_addr_log [0:63];
  logic [7:0]  aw_len_log  [0:63];
  logic [7:0]  last_len = '0;
  logic [2:0]  last_size = '0;
  logic [1:0]  last_burst = '0;
  bit          b_pending = 0, aw_wait = 0, w_wait = 0;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [63:0] p_wdata;
  logic        p_wlast;

  always @(negedge ACLK) begin
    if (aw_wait && (!M_AWVALID || M_AWADDR !== p_addr || M_AWLEN !== p_len)) stable_viol++;
    if (w_wait && M_WVALID && (M_WDATA !== p_wdata || M_WLAST !== p_wlast)) stable_viol++;
    aw_wait = M_AWVALID && !M_AWREADY && ARESETN;
    w_wait  = M_WVALID && !M_WREADY && ARESETN;
    p_addr = M_AWADDR; p_len = M_AWLEN; p_wdata = M_WDATA; p_wlast = M_WLAST;
    if (M_AWVALID) awvalid_cycles++;
    if (M_AWVALID && M_AWREADY) begin
      if (aw_total < 64) begin
        aw_addr_log[aw_total] = M_AWADDR;
        aw_len_log[aw_total]  = M_AWLEN;
      end
      last_len = M_AWLEN; last_size = M_AWSIZE; last_burst = M_AWBURST;
      beat_in = 0;
      aw_total++;
    end
    if (M_WVALID && M_WREADY) begin
      if (M_WDATA !== word(w_total) || M_WSTRB !== 8'hFF) data_err++;
      if (M_WLAST !== (beat_in == int'(last_len))) wlast_bad++;
      if (M_WLAST) begin wlast_total++; b_pending = 1; end
      beat_in++;
      w_total++;
    end
    if (WR_BUF_POP) pop_total++;
    if (WR_BUF_POP && WR_BUF_EMPTY) pop_empty++;
    if (M_BVALID && M_BREADY) begin b_total++; b_pending = 0; end
    if (!ARESETN) begin b_pending = 0; aw_wait = 0; w_wait = 0; end
  end

  // Slave drivers: ready/valid either always-on or ~30% throttled; err_b picks the failing B.
  bit rand_bp = 0;
  int err_b = -1;
  always @(posedge ACLK) begin
    #1;
    if (rand_bp) begin
      M_AWREADY = ($urandom_range(0, 9) >= 3);
      M_WREADY  = ($urandom_range(0, 9) >= 3);
      M_BVALID  = b_pending && ($urandom_range(0, 9) >= 3);
    end else begin
      M_AWREADY = 1'b1;
      M_WREADY  = 1'b1;
      M_BVALID  = b_pending;
    end
    M_BRESP = (b_total == err_b) ? 2'b10 : 2'b00;
  end

  task automatic kick(input logic [31:0] a, input logic [19:0] n);
    @(posedge ACLK); #2;
    base_addr = a; num_beats = n; start = 1'b1;
    @(posedge ACLK); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output logic err_at_done);
    ok = 0; err_at_done = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (done === 1'b1) begin ok = 1; err_at_done = wr_error; break; end
    end
    @(posedge ACLK); #2;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge ACLK);
    #2;
    if ({busy, done, wr_error, M_AWVALID, M_WVALID, M_BREADY, WR_BUF_POP} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000000",
        {busy, done, wr_error, M_AWVALID, M_WVALID, M_BREADY, WR_BUF_POP});
    end
    checks++;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
  endtask

  task automatic test_single_burst;
    int aw0 = aw_total, w0 = w_total, b0 = b_total, wl0 = wlast_total, de0 = data_err, wb0 = wlast_bad;
    bit ok; logic e;
    buf_limit = rd_ptr + 16;
    kick(32'h1000, 20'd16);
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    checks++;
    wait_done(300, ok, e);
    if (!ok) begin errors++; $display("FAIL single_done got timeout want done"); end
    checks++;
    if (aw_total - aw0 != 1) begin errors++; $display("FAIL single_aw_count got %0d want 1", aw_total - aw0); end
    checks++;
    if (aw_addr_log[aw0] !== 32'h1000 || aw_len_log[aw0] !== 8'd15) begin
      errors++; $display("FAIL single_aw got %h/%0d want 00001000/15", aw_addr_log[aw0], aw_len_log[aw0]);
    end
    checks++;
    if (last_size !== 3'd3 || last_burst !== 2'b01) begin
      errors++; $display("FAIL single_size_burst got %0d/%b want 3/01", last_size, last_burst);
    end
    checks++;
    if (w_total - w0 != 16 || wlast_total - wl0 != 1 || wlast_bad != wb0) begin
      errors++; $display("FAIL single_wbeats got %0d beats %0d wlast %0d bad want 16 1 0",
        w_total - w0, wlast_total - wl0, wlast_bad - wb0);
    end
    checks++;
    if (b_total - b0 != 1 || data_err != de0) begin
      errors++; $display("FAIL single_b_data got %0d b %0d dataerr want 1 0", b_total - b0, data_err - de0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    checks++;
  endtask

  task automatic test_multi_burst;
    int aw0 = aw_total, w0 = w_total, b0 = b_total, p0 = pop_total;
    bit ok; logic e;
    buf_limit = rd_ptr + 40;
    kick(32'h1000, 20'd40);
    wait_done(500, ok, e);
    if (!ok) begin errors++; $display("FAIL multi_done got timeout want done"); end
    checks++;
    if (aw_total - aw0 != 3) begin errors++; $display("FAIL multi_aw_count got %0d want 3", aw_total - aw0); end
    checks++;
    if (aw_addr_log[aw0] !== 32'h1000 || aw_addr_log[aw0+1] !== 32'h1080 || aw_addr_log[aw0+2] !== 32'h1100) begin
      errors++; $display("FAIL multi_addr got %h %h %h want 00001000 00001080 00001100",
        aw_addr_log[aw0], aw_addr_log[aw0+1], aw_addr_log[aw0+2]);
    end
    checks++;
    if (aw_len_log[aw0] !== 8'd15 || aw_len_log[aw0+1] !== 8'd15 || aw_len_log[aw0+2] !== 8'd7) begin
      errors++; $display("FAIL multi_len got %0d %0d %0d want 15 15 7",
        aw_len_log[aw0], aw_len_log[aw0+1], aw_len_log[aw0+2]);
    end
    checks++;
    if (pop_total - p0 != 40 || w_total - w0 != 40 || b_total - b0 != 3) begin
      errors++; $display("FAIL multi_counts got %0d pops %0d beats %0d b want 40 40 3",
        pop_total - p0, w_total - w0, b_total - b0);
    end
    checks++;
  endtask

  task automatic test_stall;
    int w0 = w_total, de0 = data_err, wb0 = wlast_bad, pe0 = pop_empty, r0 = rd_ptr;
    bit ok; logic e;
    bit got5 = 0;
    buf_limit = r0 + 5;
    kick(32'h2000, 20'd16);
    for (int i = 0; i < 100 && !got5; i++) begin
      @(posedge ACLK); #2;
      if (w_total - w0 >= 5) got5 = 1;
    end
    if (!got5) begin errors++; $display("FAIL stall_reach5 got %0d want 5", w_total - w0); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (M_WVALID !== 1'b0 || WR_BUF_POP !== 1'b0) begin
        errors++; $display("FAIL stall_gap cycle %0d got wvalid=%b pop=%b want 0 0", i, M_WVALID, WR_BUF_POP);
      end
      checks++;
    end
    buf_limit = r0 + 16;
    wait_done(300, ok, e);
    if (!ok) begin errors++; $display("FAIL stall_done got timeout want done"); end
    checks++;
    if (w_total - w0 != 16 || data_err != de0 || wlast_bad != wb0 || pop_empty != pe0) begin
      errors++; $display("FAIL stall_order got %0d beats %0d dataerr %0d wlastbad %0d popempty want 16 0 0 0",
        w_total - w0, data_err - de0, wlast_bad - wb0, pop_empty - pe0);
    end
    checks++;
  endtask

  task automatic test_backpressure;
    int aw0 = aw_total, w0 = w_total, b0 = b_total, wl0 = wlast_total;
    int de0 = data_err, wb0 = wlast_bad, sv0 = stable_viol;
    bit ok; logic e;
    rand_bp = 1;
    buf_limit = rd_ptr + 40;
    kick(32'h3000, 20'd40);
    wait_done(3000, ok, e);
    rand_bp = 0;
    if (!ok) begin errors++; $display("FAIL bp_done got timeout want done"); end
    checks++;
    if (stable_viol != sv0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stable_viol - sv0); end
    checks++;
    if (aw_total - aw0 != 3 || w_total - w0 != 40 || wlast_total - wl0 != 3 || b_total - b0 != 3) begin
      errors++; $display("FAIL bp_counts got aw %0d w %0d wlast %0d b %0d want 3 40 3 3",
        aw_total - aw0, w_total - w0, wlast_total - wl0, b_total - b0);
    end
    checks++;
    if (wlast_bad != wb0 || data_err != de0) begin
      errors++; $display("FAIL bp_wlast_data got %0d wlastbad %0d dataerr want 0 0", wlast_bad - wb0, data_err - de0);
    end
    checks++;
  endtask

  task automatic test_error;
    int b0 = b_total, av0;
    bit ok; logic e;
    err_b = b_total + 1;
    buf_limit = rd_ptr + 40;
    kick(32'h4000, 20'd40);
    wait_done(500, ok, e);
    err_b = -1;
    if (!ok || e !== 1'b1) begin errors++; $display("FAIL err_at_done got ok=%0d wr_error=%b want 1 1", ok, e); end
    checks++;
    if (b_total - b0 != 3) begin errors++; $display("FAIL err_completes got %0d b want 3", b_total - b0); end
    checks++;
    if (wr_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", wr_error); end
    checks++;
    av0 = awvalid_cycles;
    kick(32'h5000, 20'd0);
    if (done !== 1'b1 || wr_error !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b wr_error=%b want 1 0", done, wr_error);
    end
    checks++;
    repeat (3) @(posedge ACLK);
    #2;
    if (done !== 1'b0 || awvalid_cycles != av0) begin
      errors++; $display("FAIL zero_quiet got done=%b awvalid_cycles=%0d want 0 0", done, awvalid_cycles - av0);
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int w0 = w_total, aw0, w1, de0, wb0;
    bit ok; logic e;
    bit got2 = 0;
    buf_limit = rd_ptr + 20;
    kick(32'h6000, 20'd20);
    for (int i = 0; i < 100 && !got2; i++) begin
      @(posedge ACLK); #2;
      if (w_total - w0 >= 2) got2 = 1;
    end
    if (!got2) begin errors++; $display("FAIL rstmid_reach got %0d want 2", w_total - w0); end
    checks++;
    ARESETN = 1'b0;
    @(posedge ACLK); #2;
    if ({busy, done, wr_error, M_AWVALID, M_WVALID, M_WLAST, M_BREADY, WR_BUF_POP} !== 8'b0) begin
      errors++; $display("FAIL rstmid_outputs got %b want 00000000",
        {busy, done, wr_error, M_AWVALID, M_WVALID, M_WLAST, M_BREADY, WR_BUF_POP});
    end
    checks++;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    aw0 = aw_total; w1 = w_total; de0 = data_err; wb0 = wlast_bad;
    buf_limit = rd_ptr + 16;
    kick(32'h7000, 20'd16);
    wait_done(300, ok, e);
    if (!ok) begin errors++; $display("FAIL rstmid_restart got timeout want done"); end
    checks++;
    if (aw_total - aw0 != 1 || aw_addr_log[aw0] !== 32'h7000 || aw_len_log[aw0] !== 8'd15) begin
      errors++; $display("FAIL rstmid_aw got %0d aw addr %h len %0d want 1 00007000 15",
        aw_total - aw0, aw_addr_log[aw0], aw_len_log[aw0]);
    end
    checks++;
    if (w_total - w1 != 16 || data_err != de0 || wlast_bad != wb0) begin
      errors++; $display("FAIL rstmid_w got %0d beats %0d dataerr %0d wlastbad want 16 0 0",
        w_total - w1, data_err - de0, wlast_bad - wb0);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_stall();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
